// File: rtl/cpu_axi_master_bridge.sv
// CPU single-word memory port to single-beat AXI4 master bridge.
// Ports: clk/rst (sync, active-high); cpu_req/we/addr/wdata in,
//        cpu_rdata/stall/err out; AXI4 AR/R/AW/W/B master channels.
// Option: AXI_MST_RSP_REG_EN adds a RESP cycle and fully registers
//         cpu_rdata (no RDATA bypass, +1 cycle latency).
module cpu_axi_master_bridge #(
   parameter logic [3:0] ID_VAL = 4'd0,
   parameter int          ADDR_W = 32,
   parameter int          DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cpu_req,
   input  logic [DATA_W/8-1:0] cpu_we,
   input  logic [ADDR_W-1:0]   cpu_addr,
   input  logic [DATA_W-1:0]   cpu_wdata,
   output logic [DATA_W-1:0]   cpu_rdata,
   output logic                cpu_stall,
   output logic                cpu_err,
   output logic [3:0]          ARID,
   output logic [ADDR_W-1:0]   ARADDR,
   output logic [3:0]          ARLEN,
   output logic [2:0]          ARSIZE,
   output logic [1:0]          ARBURST,
   output logic                ARVALID,
   input  logic                ARREADY,
   input  logic [3:0]          RID,
   input  logic [DATA_W-1:0]   RDATA,
   input  logic [1:0]          RRESP,
   input  logic                RLAST,
   input  logic                RVALID,
   output logic                RREADY,
   output logic [3:0]          AWID,
   output logic [ADDR_W-1:0]   AWADDR,
   output logic [3:0]          AWLEN,
   output logic [2:0]          AWSIZE,
   output logic [1:0]          AWBURST,
   output logic                AWVALID,
   input  logic                AWREADY,
   output logic [DATA_W-1:0]   WDATA,
   output logic [DATA_W/8-1:0] WSTRB,
   output logic                WLAST,
   output logic                WVALID,
   input  logic                WREADY,
   input  logic [3:0]          BID,
   input  logic [1:0]          BRESP,
   input  logic                BVALID,
   output logic                BREADY
);

   typedef enum logic [2:0] {
      IDLE,
      RD_A,
      RD_D,
      WR_A,
      WR_B,
      RESP
   } state_t;

`ifdef AXI_MST_RSP_REG_EN
   localparam state_t RSP_NXT = RESP;
`else
   localparam state_t RSP_NXT = IDLE;
`endif

   state_t              state, state_nxt;
   logic                aw_done, w_done;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] we_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                err_q;
   logic                r_hs, b_hs, done;
   logic                unused_in;

   // Single-beat response phases; IDs and RLAST carry no information here.
   assign unused_in = ^{RID, BID, RLAST};

   assign r_hs = (state == RD_D) & RVALID;
   assign b_hs = (state == WR_B) & BVALID;

   assign ARID    = ID_VAL;
   assign ARADDR  = addr_q;
   assign ARLEN   = 4'd0;
   assign ARSIZE  = 3'b010;
   assign ARBURST = 2'b01;
   assign AWID    = ID_VAL;
   assign AWADDR  = addr_q;
   assign AWLEN   = 4'd0;
   assign AWSIZE  = 3'b010;
   assign AWBURST = 2'b01;
   assign WDATA   = wdata_q;
   assign WSTRB   = we_q;
   assign WLAST   = 1'b1;
   assign cpu_err = err_q;

`ifdef AXI_MST_RSP_REG_EN
   assign done      = (state == RESP);
   assign cpu_rdata = rdata_q;
`else
   assign done      = r_hs | b_hs;
   // Bypass lets the load data reach the CPU in the handshake cycle.
   assign cpu_rdata = r_hs ? RDATA : rdata_q;
`endif

   assign cpu_stall = (cpu_req | (state != IDLE)) & ~done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && cpu_req) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            we_q    <= cpu_we;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (AWVALID && AWREADY) aw_done <= 1'b1;
         if (WVALID && WREADY)   w_done  <= 1'b1;
         if (r_hs) begin
            rdata_q <= RDATA;
            if (RRESP != 2'b00) err_q <= 1'b1;
         end
         if (b_hs && BRESP != 2'b00) err_q <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      ARVALID   = 1'b0;
      RREADY    = 1'b0;
      AWVALID   = 1'b0;
      WVALID    = 1'b0;
      BREADY    = 1'b0;
      unique case (state)
         IDLE: begin
            if (cpu_req) state_nxt = (|cpu_we) ? WR_A : RD_A;
         end
         RD_A: begin
            ARVALID = 1'b1;
            if (ARREADY) state_nxt = RD_D;
         end
         RD_D: begin
            RREADY = 1'b1;
            if (RVALID) state_nxt = RSP_NXT;
         end
         WR_A: begin
            // AW and W complete independently, possibly in one cycle.
            AWVALID = ~aw_done;
            WVALID  = ~w_done;
            if ((aw_done | AWREADY) & (w_done | WREADY))
               state_nxt = WR_B;
         end
         WR_B: begin
            BREADY = 1'b1;
            if (BVALID) state_nxt = RSP_NXT;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
